seg_disp_arbiter: RTL and testbench
===================================

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning CLK cycles per 1 ms tick.
REQ-002 SHALL have parameter HOLD_MS, default 2000, meaning overlay duration in ticks (>=2).
REQ-003 SHALL have parameter BLINK_MS, default 250, meaning track-blink half-period in ticks (>=1).
REQ-004 SHALL have port CLK  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port TIME_S  input  16  binary playback seconds, passed through to the display.
REQ-007 SHALL have port TRACK_BCD  input  12  current track number, 3 BCD digits.
REQ-008 SHALL have port VOL_BCD  input  8  current volume, 2 BCD digits.
REQ-009 SHALL have port VOL_REQ  input  1  single-cycle pulse: volume changed.
REQ-010 SHALL have port TRK_REQ  input  1  single-cycle pulse: track changed.
REQ-011 SHALL have port DO  output  32  display word for the 8-digit scanner; [31:16] four BCD nibbles, 4'hF = blank digit; [15:0] binary seconds.
REQ-012 SHALL have port SRC  output  2  active source: 0 IDLE, 1 VOL, 2 TRK.

Function
REQ-013 SHALL generate a one-cycle tick every TICK_DIV CLK cycles from a free-running counter.
REQ-014 SHALL implement FSM states IDLE, VOL, TRK; SRC equals the state code.
REQ-015 SHALL register DO and SRC, one-cycle latency from state/input change to output.
REQ-016 SHALL drive DO[15:0] = TIME_S (registered) in every state.
REQ-017 IDLE SHALL drive DO[31:16] = {4'hF, TRACK_BCD}.
REQ-018 VOL SHALL drive DO[31:16] = {4'hF, 4'hF, VOL_BCD}, tracking live VOL_BCD.
REQ-019 TRK SHALL alternate DO[31:16] between {4'hF, TRACK_BCD} (on phase, first) and 16'hFFFF (off), toggling every BLINK_MS ticks.
REQ-020 Entry to VOL or TRK SHALL load hold counter with HOLD_MS and blink counter with BLINK_MS; each decrements on tick.
REQ-021 On the tick at which hold counter equals 1 the state SHALL exit: to TRK if pending flag set (clearing it), else to IDLE.
REQ-022 VOL_REQ in any state SHALL enter/restart VOL (hold reload); VOL preempts TRK.
REQ-023 TRK_REQ in IDLE or TRK SHALL enter/restart TRK (hold and blink reload, on phase).
REQ-024 TRK_REQ in VOL SHALL set a one-deep pending flag; further TRK_REQ while pending are absorbed.
REQ-025 Simultaneous VOL_REQ and TRK_REQ SHALL enter VOL and set pending.
REQ-026 VOL_REQ preempting TRK SHALL set pending so TRK is replayed in full afterwards.
REQ-027 A request coinciding with the expiry tick SHALL take precedence over the expiry transition.
REQ-028 Hold and blink counters SHALL be wide enough for their parameters; no wrap-around.

Reset
REQ-029 RST SHALL force state IDLE, pending 0, tick/hold/blink counters 0, DO = {16'hFFFF, 16'h0000}, SRC = 0.
REQ-030 RST mid-overlay SHALL abandon it; the cycle after RST deasserts, state is IDLE with no pending replay.
REQ-031 Requests asserted while RST is high SHALL be ignored.

Structure
REQ-032 Shared package seg_disp_pkg SHALL hold state encoding (IDLE/VOL/TRK) and BLANK_NIBBLE = 4'hF.
REQ-033 Tick generation SHALL be sub-module seg_tick_gen (parameter TICK_DIV, ports CLK, RST, TICK).
REQ-034 FSM, counters and output mux SHALL reside in seg_disp_arbiter; target 120-400 lines RTL.

Verification (TICK_DIV=4, HOLD_MS=5, BLINK_MS=2)
REQ-035 Reset release, TRACK_BCD=12'h042, TIME_S=16'd75 -> within 2 cycles DO=32'hF042_004B, SRC=0.
REQ-036 VOL_REQ pulse, VOL_BCD=8'h37 -> next cycle SRC=1, DO[31:16]=16'hFF37; returns to SRC=0 after 5 ticks (20 cycles +/-4).
REQ-037 TRK_REQ, TRACK_BCD=12'h007 -> DO[31:16] sequence F007,FFFF,F007 per 2 ticks, IDLE after 5 ticks.
REQ-038 VOL_REQ and TRK_REQ same cycle -> VOL 5 ticks, then TRK 5 ticks, then IDLE.
REQ-039 VOL_REQ re-pulsed every 3 ticks for 12 ticks -> SRC stays 1 throughout, exits 5 ticks after last pulse.
REQ-040 RST asserted during TRK with pending set -> DO=32'hFFFF_0000, then IDLE, no TRK replay.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared definitions for the segment-display source arbiter.
// State codes double as the externally visible SRC value.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VOL  = 2'd1,
    ST_TRK  = 2'd2
  } state_t;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running divider producing a one-cycle TICK every TICK_DIV clocks.
module seg_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign TICK = (r_cnt == LAST);

endmodule

// File: rtl/seg_disp_arbiter.sv
// Chooses what the 8-digit display shows: idle track view, a timed volume
// overlay, or a timed blinking track overlay; volume always wins.
module seg_disp_arbiter
  import seg_disp_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int HOLD_MS  = 2000,
  parameter int BLINK_MS = 250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] TIME_S,
  input  logic [11:0] TRACK_BCD,
  input  logic [7:0]  VOL_BCD,
  input  logic        VOL_REQ,
  input  logic        TRK_REQ,
  output logic [31:0] DO,
  output logic [1:0]  SRC
);

  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_MS);
  localparam logic [BW-1:0] BLINK_LD = BW'(BLINK_MS);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [BW-1:0] BLINK_ONE = BW'(1);

  logic          w_tick;
  state_t        r_state, w_state_next;
  logic          r_pend, w_pend_next;
  logic [HW-1:0] r_hold, w_hold_next;
  logic [BW-1:0] r_blink, w_blink_next;
  logic          r_phase, w_phase_next;
  logic [15:0]   w_upper;
  logic [31:0]   r_do;
  logic [1:0]    r_src;

  seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    w_hold_next  = r_hold;
    w_blink_next = r_blink;
    w_phase_next = r_phase;
    if (VOL_REQ) begin
      // Preempting a running track overlay queues it for a full replay
      w_state_next = ST_VOL;
      w_hold_next  = HOLD_LD;
      w_blink_next = BLINK_LD;
      w_phase_next = 1'b1;
      w_pend_next  = r_pend | TRK_REQ | (r_state == ST_TRK);
    end else if (TRK_REQ && r_state != ST_VOL) begin
      w_state_next = ST_TRK;
      w_hold_next  = HOLD_LD;
      w_blink_next = BLINK_LD;
      w_phase_next = 1'b1;
    end else begin
      w_pend_next = r_pend | TRK_REQ;
      if (w_tick && r_state != ST_IDLE) begin
        if (r_hold == HOLD_ONE) begin
          if (w_pend_next) begin
            w_state_next = ST_TRK;
            w_hold_next  = HOLD_LD;
            w_blink_next = BLINK_LD;
            w_phase_next = 1'b1;
            w_pend_next  = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
            w_hold_next  = '0;
            w_blink_next = '0;
            w_phase_next = 1'b1;
          end
        end else begin
          w_hold_next = r_hold - 1'b1;
          if (r_blink == BLINK_ONE) begin
            w_blink_next = BLINK_LD;
            w_phase_next = ~r_phase;
          end else if (r_blink != '0) begin
            w_blink_next = r_blink - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_upper = {BLANK_NIBBLE, TRACK_BCD};
    case (w_state_next)
      ST_VOL:  w_upper = {BLANK_NIBBLE, BLANK_NIBBLE, VOL_BCD};
      ST_TRK:  w_upper = w_phase_next ? {BLANK_NIBBLE, TRACK_BCD} : 16'hFFFF;
      default: w_upper = {BLANK_NIBBLE, TRACK_BCD};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_hold  <= '0;
      r_blink <= '0;
      r_phase <= 1'b1;
      r_do    <= {16'hFFFF, 16'h0000};
      r_src   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_hold  <= w_hold_next;
      r_blink <= w_blink_next;
      r_phase <= w_phase_next;
      r_do    <= {w_upper, TIME_S};
      r_src   <= w_state_next;
    end
  end

  assign DO  = r_do;
  assign SRC = r_src;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Randomized scoreboard bench: a tick-level overlay model predicts DO/SRC
// after every clock; a separate monitor pops and compares.
module tb_seg_disp_arbiter;

  localparam int TD = 4;
  localparam int HM = 5;
  localparam int BM = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] TIME_S = '0;
  logic [11:0] TRACK_BCD = '0;
  logic [7:0]  VOL_BCD = '0;
  logic        VOL_REQ = 1'b0;
  logic        TRK_REQ = 1'b0;
  logic [31:0] DO;
  logic [1:0]  SRC;

  seg_disp_arbiter #(.TICK_DIV(TD), .HOLD_MS(HM), .BLINK_MS(BM)) dut (
    .CLK(CLK), .RST(RST), .TIME_S(TIME_S), .TRACK_BCD(TRACK_BCD),
    .VOL_BCD(VOL_BCD), .VOL_REQ(VOL_REQ), .TRK_REQ(TRK_REQ),
    .DO(DO), .SRC(SRC)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   started = 1'b0;

  // Model: mode 0 idle / 1 volume / 2 track; rem = ticks left in overlay;
  // el = ticks spent in the current track overlay; blink phase derived from el.
  int mode = 0, rem = 0, el = 0, pend = 0, ncyc = 0;
  logic [11:0] cur_trk = 12'h042;
  logic [7:0]  cur_vol = 8'h37;
  logic [15:0] cur_time = 16'd75;

  task automatic step(input bit rst, input bit vr, input bit tr);
    exp_t e;
    bit tick;
    logic [15:0] up;
    @(negedge CLK);
    RST = rst; VOL_REQ = vr; TRK_REQ = tr;
    TRACK_BCD = cur_trk; VOL_BCD = cur_vol; TIME_S = cur_time;
    if (rst) begin
      mode = 0; rem = 0; el = 0; pend = 0; ncyc = 0;
      e.d = 32'hFFFF_0000; e.s = 2'd0;
    end else begin
      tick = (ncyc % TD) == TD - 1;
      ncyc++;
      if (vr) begin
        if (tr || mode == 2) pend = 1;
        mode = 1; rem = HM;
      end else if (tr && mode != 1) begin
        mode = 2; rem = HM; el = 0;
      end else begin
        if (tr) pend = 1;
        if (tick && mode != 0) begin
          if (rem == 1) begin
            if (pend != 0) begin mode = 2; rem = HM; el = 0; pend = 0; end
            else mode = 0;
          end else begin
            rem--;
            if (mode == 2) el++;
          end
        end
      end
      if (mode == 1) up = {8'hFF, cur_vol};
      else if (mode == 2 && ((el / BM) % 2) == 1) up = 16'hFFFF;
      else up = {4'hF, cur_trk};
      e.d = {up, cur_time}; e.s = 2'(mode);
    end
    q.push_back(e);
    started = 1'b1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: output is presented every clock, compared 1 time unit after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({DO, SRC} !== {e.d, e.s}) begin
          n_bad++;
          $display("FAIL out[%0d]: DO=%h SRC=%0d, expected DO=%h SRC=%0d",
                   n_vec, DO, SRC, e.d, e.s);
        end
      end else if (started) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_empty: no expectation queued at t=%0t", $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d vectors", n_vec);
    $fatal(1);
  end

  initial begin
    // Reset, then idle view with track 042 and 75 s
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(4);
    // Single volume overlay
    step(1'b0, 1'b1, 1'b0);
    idle(25);
    // Single track overlay with blink
    cur_trk = 12'h007;
    step(1'b0, 1'b0, 1'b1);
    idle(25);
    // Simultaneous requests: volume then track replay
    step(1'b0, 1'b1, 1'b1);
    idle(45);
    // Volume re-pulsed every 3 ticks for 12 ticks
    for (int p = 0; p < 5; p++) begin
      step(1'b0, 1'b1, 1'b0);
      idle(3 * TD - 1);
    end
    idle(15);
    // Track preempted by volume, then reset abandons pending replay
    step(1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b0, 1'b1, 1'b0);
    idle(6);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    idle(45);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cur_time = 16'($urandom);
      if ($urandom_range(0, 15) == 0) cur_trk = 12'($urandom);
      if ($urandom_range(0, 15) == 0) cur_vol = 8'($urandom);
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 29) == 0);
    end
    @(posedge CLK);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
